// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture controller:
// capture FSM state encoding and default buffer/count widths.
package la_pkg;

    localparam int LA_ADDR_W = 5;
    localparam int LA_CNT_W  = 5;

    typedef enum logic [1:0] {
        LA_IDLE  = 2'd0,
        LA_ARMED = 2'd1,
        LA_POST  = 2'd2,
        LA_DONE  = 2'd3
    } la_state_t;

endpackage

// File: rtl/la_addr_ctr.sv
// Sample buffer write-address counter: ADDR_W-bit wrap counter with a
// synchronous clear (priority over increment) and a wrap pulse that is high
// in the cycle whose increment rolls the address from all-ones back to zero.
module la_addr_ctr
    import la_pkg::*;
#(
    parameter int ADDR_W = LA_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    // A clear in the same cycle suppresses the wrap, since the address is forced to 0.
    assign wrap = inc & ~clr & (addr == {ADDR_W{1'b1}});

    // Address register: clear wins over increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: run/write-enable/status-strobe control
// plus a circular sample buffer address, arm/trigger FSM and a programmable
// post-trigger sample count.
// Optional build macro LA_TRIG_EDGE_EN: trigger on the rising edge of trig
// instead of its level.
//
// Handshake note: there is no valid/ready pair here; a sample is written in
// every cycle where la_we is high, and la_addr advances on that same edge.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int ADDR_W = LA_ADDR_W,
    parameter int CNT_W  = LA_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              step_en,
    input  logic              in_init,
    input  logic              stop_n,
    input  logic              arm,
    input  logic              trig,
    input  logic [CNT_W-1:0]  post_cnt,
    output logic              la_run,
    output logic              la_we,
    output logic [ADDR_W-1:0] la_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              wrapped,
    output logic              done,
    output logic              sts_ce,
    output la_state_t         dbg_state
);

    la_state_t        state, state_d;
    logic [CNT_W-1:0] cnt;
    logic             in_init_q;
    logic             la_run_q;
    logic             done_pulse;
    logic             wr;
    logic             trig_eff;
    logic             trig_hit;
    logic             ctr_wrap;

    // Running unless the processor has been in init for two consecutive cycles.
    assign la_run = step_en | ~(in_init & in_init_q);

    // Sample write qualifier: only while capturing and not stopped.
    assign wr = stop_n & la_run & ((state == LA_ARMED) | (state == LA_POST));

`ifdef LA_TRIG_EDGE_EN
    logic trig_q;

    // Previous trig level, tracked every cycle independent of writes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
        end
    end

    assign trig_eff = trig & ~trig_q;
`else
    assign trig_eff = trig;
`endif

    // A trigger only counts when it coincides with a written pre-trigger sample.
    assign trig_hit = (state == LA_ARMED) & wr & trig_eff;

    la_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (arm),
        .inc   (wr),
        .addr  (la_addr),
        .wrap  (ctr_wrap)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= LA_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next-state logic; arm overrides every other condition.
    always_comb begin
        state_d = state;
        if (arm) begin
            state_d = LA_ARMED;
        end else begin
            case (state)
                LA_ARMED: begin
                    if (trig_hit) begin
                        state_d = (post_cnt == '0) ? LA_DONE : LA_POST;
                    end
                end
                LA_POST: begin
                    if (wr && (cnt == CNT_W'(1))) begin
                        state_d = LA_DONE;
                    end
                end
                default: state_d = state;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        la_we     = wr;
        done      = (state == LA_DONE);
        sts_ce    = (~la_run & la_run_q) | done_pulse;
        dbg_state = state;
    end

    // Run history and the one-cycle strobe marking entry into DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_init_q  <= 1'b0;
            la_run_q   <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            in_init_q  <= in_init;
            la_run_q   <= la_run;
            done_pulse <= (state_d == LA_DONE) & (state != LA_DONE);
        end
    end

    // Post-trigger countdown, trigger address and sticky pre-trigger wrap flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            trig_addr <= '0;
            wrapped   <= 1'b0;
        end else if (arm) begin
            cnt       <= '0;
            trig_addr <= '0;
            wrapped   <= 1'b0;
        end else begin
            if (trig_hit) begin
                cnt       <= post_cnt;
                trig_addr <= la_addr;
            end else if ((state == LA_POST) && wr && (cnt != CNT_W'(1))) begin
                cnt <= cnt - CNT_W'(1);
            end
            if ((state == LA_ARMED) && ctr_wrap) begin
                wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Self-checking bench for la_capture_ctrl: directed capture scenarios then
// randomized stimulus, compared every cycle against a write-counting model.
module tb_la_capture_ctrl;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              step_en, in_init, stop_n, arm, trig;
    logic [CNT_W-1:0]  post_cnt;
    logic              la_run, la_we, wrapped, done, sts_ce;
    logic [ADDR_W-1:0] la_addr, trig_addr;
    la_pkg::la_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // Model: capture tracked as counts of writes since the last arm.
    int m_phase;      // 0 idle, 1 pre-trigger, 2 post-trigger, 3 complete
    int m_n;          // total writes since arm
    int m_armed_w;    // writes made before/including the trigger sample
    int m_post_left;  // post-trigger writes still owed
    int m_trig_addr;
    bit m_init_q, m_run_q, m_done_flag, m_trig_q;

    la_capture_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .step_en   (step_en),
        .in_init   (in_init),
        .stop_n    (stop_n),
        .arm       (arm),
        .trig      (trig),
        .post_cnt  (post_cnt),
        .la_run    (la_run),
        .la_we     (la_we),
        .la_addr   (la_addr),
        .trig_addr (trig_addr),
        .wrapped   (wrapped),
        .done      (done),
        .sts_ce    (sts_ce),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_armed_w = 0; m_post_left = 0; m_trig_addr = 0;
        m_init_q = 0; m_run_q = 0; m_done_flag = 0; m_trig_q = 0;
    endtask

    // Check all outputs against the model, take one clock edge, advance the model.
    task automatic tick();
        bit run, wr, trg;
        #1;
        run = step_en | ~(in_init & m_init_q);
        wr  = stop_n & run & (m_phase == 1 || m_phase == 2);
        check("la_run", la_run, run);
        check("la_we", la_we, wr);
        check("la_addr", la_addr, m_n % DEPTH);
        check("trig_addr", trig_addr, m_trig_addr);
        check("wrapped", wrapped, m_armed_w >= DEPTH);
        check("done", done, m_phase == 3);
        check("sts_ce", sts_ce, (~run & m_run_q) | m_done_flag);
        @(posedge CLK);
`ifdef LA_TRIG_EDGE_EN
        trg = trig & ~m_trig_q;
`else
        trg = trig;
`endif
        m_done_flag = 0;
        if (arm) begin
            m_n = 0; m_armed_w = 0; m_trig_addr = 0; m_post_left = 0; m_phase = 1;
        end else if (wr) begin
            if (m_phase == 1) begin
                if (trg) begin
                    m_trig_addr = m_n % DEPTH;
                    if (post_cnt == 0) begin
                        m_phase = 3; m_done_flag = 1;
                    end else begin
                        m_phase = 2; m_post_left = post_cnt;
                    end
                end
                m_armed_w++;
                m_n++;
            end else begin
                m_n++;
                m_post_left--;
                if (m_post_left == 0) begin
                    m_phase = 3; m_done_flag = 1;
                end
            end
        end
        m_init_q = in_init;
        m_run_q  = run;
        m_trig_q = trig;
        @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, la_we, 0);
        check({tag, "_addr"}, la_addr, 0);
        check({tag, "_trig_addr"}, trig_addr, 0);
        check({tag, "_wrapped"}, wrapped, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sts_ce"}, sts_ce, 0);
    endtask

    initial begin
        // Reset with the processor held in init.
        RST_N = 1'b0; step_en = 1'b0; in_init = 1'b1; stop_n = 1'b1;
        arm = 1'b0; trig = 1'b0; post_cnt = '0;
        model_reset();
        @(negedge CLK);
        #1 check_reset_values("rst");
        @(negedge CLK);
        RST_N = 1'b1;
        ticks(4);

        // Trigger on the 10th write, three post-trigger samples.
        in_init = 1'b0;
        tick();
        post_cnt = 5'd3;
        do_arm();
        ticks(9);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        ticks(5);
        check("s2_trig_addr", trig_addr, 9);
        check("s2_addr", la_addr, 13);
        check("s2_done", done, 1);

        // 40 writes before the trigger, no post-trigger samples.
        post_cnt = 5'd0;
        do_arm();
        ticks(40);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        ticks(2);
        check("s3_wrapped", wrapped, 1);
        check("s3_trig_addr", trig_addr, 8);
        check("s3_addr", la_addr, 9);

        // Stop during post-trigger countdown, then resume.
        post_cnt = 5'd6;
        do_arm();
        ticks(3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        ticks(2);
        stop_n = 1'b0;
        ticks(5);
        stop_n = 1'b1;
        ticks(6);
        check("s4_addr", la_addr, 10);
        check("s4_done", done, 1);

        // Arm coinciding with trig while armed.
        post_cnt = 5'd2;
        do_arm();
        ticks(3);
        arm = 1'b1; trig = 1'b1;
        tick();
        arm = 1'b0; trig = 1'b0;
        check("s5_addr", la_addr, 0);
        check("s5_trig_addr", trig_addr, 0);
        check("s5_done", done, 0);
        ticks(2);

        // Trig held high from before arm.
        trig = 1'b1;
        ticks(2);
        do_arm();
        ticks(5);
        trig = 1'b0;
        tick();
        trig = 1'b1;
        ticks(4);
        trig = 1'b0;
`ifdef LA_TRIG_EDGE_EN
        check("s6_trig_addr", trig_addr, 6);
        check("s6_addr", la_addr, 9);
`else
        check("s6_trig_addr", trig_addr, 0);
        check("s6_addr", la_addr, 3);
`endif
        check("s6_done", done, 1);

        // Asynchronous reset in the middle of a capture.
        post_cnt = 5'd20;
        do_arm();
        ticks(7);
        #2 RST_N = 1'b0;
        #1 check_reset_values("arst");
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        in_init = 1'b1;
        ticks(3);
        in_init = 1'b0;

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            arm      = ($urandom_range(0, 39) == 0);
            trig     = ($urandom_range(0, 9) == 0);
            stop_n   = ($urandom_range(0, 5) != 0);
            step_en  = $urandom_range(0, 1);
            in_init  = ($urandom_range(0, 7) == 0);
            post_cnt = CNT_W'($urandom_range(0, 12));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_capture_ctrl.md
Name: la_capture_ctrl

Overview:
- Logic-analyser capture controller for the DLX debug path; successor to the fixed single-step run/write-enable control.
- Keeps the run/write-enable/status-strobe semantics and adds a parametrised circular sample buffer address, arm/trigger handling, and a programmable post-trigger sample count.
- Drives the LA sample RAM (write enable and address) and the status register clock-enable, under control of the monitor/step logic.

Parameters:
- ADDR_W, 5, log2 of sample buffer depth; buffer holds 2^ADDR_W samples.
- CNT_W, 5, width of post-trigger count; must satisfy CNT_W <= ADDR_W.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- step_en  in  1  single-step enable from monitor.
- in_init  in  1  processor in init/reset phase.
- stop_n  in  1  low suppresses sample writes.
- arm  in  1  one-cycle pulse; clears buffer state, starts capture.
- trig  in  1  trigger condition.
- post_cnt  in  CNT_W  samples written after the trigger sample.
- la_run  out  1  LA running.
- la_we  out  1  sample RAM write enable.
- la_addr  out  ADDR_W  sample RAM write address.
- trig_addr  out  ADDR_W  address at which the trigger sample was written.
- wrapped  out  1  buffer has wrapped at least once since arm.
- done  out  1  capture complete (level).
- sts_ce  out  1  status register clock enable (one-cycle pulse).

Behaviour:
- Registers in_init_q and la_run_q; both reset to 0.
- la_run is combinational: step_en | ~(in_init & in_init_q). After reset with in_init=1, la_run=1 for one cycle only, unless step_en=1.
- States:
  - IDLE: reset state.
  - ARMED: pre-trigger capture, circular write.
  - POST: post-trigger countdown.
  - DONE: capture complete.
- Sample write qualifier wr = stop_n & la_run & (state==ARMED | state==POST). la_we = wr, combinational.
- la_addr:
  - Increments by 1 modulo 2^ADDR_W at each clock edge with wr=1.
  - In ARMED, an increment from 2^ADDR_W-1 to 0 sets wrapped (sticky until arm or reset).
  - In POST, wrapping is permitted silently (overwrites oldest samples).
- Transitions:
  - IDLE -arm-> ARMED.
  - ARMED -(trig & wr)-> POST. Same edge: trig_addr<=la_addr, cnt<=post_cnt. If post_cnt==0, go directly to DONE instead.
  - POST: each wr with cnt!=1 decrements cnt; wr with cnt==1 -> DONE.
  - DONE -arm-> ARMED.
- trig while wr=0 (stop_n low, or not running) is ignored; no sample is written and no transition occurs.
- arm in any state: la_addr<=0, wrapped<=0, done<=0, trig_addr<=0, cnt<=0, state<=ARMED. arm has priority over trig and over wr in the same cycle; that cycle's write still occurs (la_we is combinational on the pre-arm state), but the address is forced to 0.
- done=1 exactly while state==DONE. In DONE, la_we=0 and la_addr holds. la_addr then points one past the last written sample; this is the oldest sample if wrapped=1.
- sts_ce = (~la_run & la_run_q) | done_pulse.
  - done_pulse is a registered one-cycle pulse on the cycle after entry into DONE.
  - Both sources coinciding give a single-cycle sts_ce.
- Reset values:
  - Outputs: la_addr=0, trig_addr=0, wrapped=0, done=0, sts_ce=0.
  - Internal: state=IDLE, cnt=0.
  - la_we=0, since state is IDLE.
- Reset mid-capture discards all state immediately (asynchronous).

Optional Feature:
- LA_TRIG_EDGE_EN defined:
  - A registered trig_q (reset 0) is added.
  - The effective trigger is trig & ~trig_q (rising edge only).
  - trig_q updates every cycle regardless of wr.
- Not defined: level trigger; a trig held high triggers on the first qualified write in ARMED.

Decomposition:
- Shared package la_pkg: state encoding constants (LA_IDLE=2'd0, LA_ARMED=2'd1, LA_POST=2'd2, LA_DONE=2'd3) and default widths (LA_ADDR_W=5, LA_CNT_W=5).
- One natural sub-module: la_addr_ctr (ADDR_W-bit wrap counter with sync clear, increment enable, and wrap pulse output).
- The FSM, post-trigger counter, and strobe logic stay in the top module.

Test Plan:
- Reset, in_init=1, step_en=0 -> la_run=1 on the first cycle after RST_N deassert, then 0; sts_ce pulses once when la_run falls; la_we=0 throughout (IDLE).
- arm, la_run=1, stop_n=1, trig at 10th write, post_cnt=3 -> trig_addr=9; la_we high for 3 more cycles; done=1 with la_addr=13; sts_ce pulses once on the cycle after DONE entry.
- ADDR_W=5, 40 writes before trig, post_cnt=0 -> wrapped=1, trig_addr=8, done on the next cycle, la_addr=9.
- stop_n=0 during POST for 5 cycles -> la_we=0, cnt and la_addr frozen; capture resumes when stop_n returns to 1.
- arm asserted in the same cycle as trig in ARMED -> state stays ARMED, la_addr=0, trig_addr=0; trig ignored.
- LA_TRIG_EDGE_EN defined, trig held high from before arm -> no trigger until trig toggles 0->1; undefined -> trigger on the first write after arm.
